// File: rtl/arm_mc_pkg.sv
// Shared types and encodings for the multicycle ARM control unit:
// FSM states, instruction-field codes, mux-select encodings and command decode.
package arm_mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_FAULT
  } state_t;

  localparam logic [1:0] ALU_ADD = 2'b00, ALU_SUB = 2'b01, ALU_AND = 2'b10, ALU_ORR = 2'b11;
  localparam logic [1:0] OP_DP = 2'b00, OP_MEM = 2'b01, OP_BR = 2'b10, OP_BAD = 2'b11;

  localparam logic [3:0] CMD_AND = 4'b0000, CMD_SUB = 4'b0010, CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010, CMD_ORR = 4'b1100;

  localparam logic [3:0] COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF;

  localparam logic [1:0] RES_ALUOUT = 2'b00, RES_RDATA = 2'b01, RES_ALU = 2'b10;
  localparam logic [1:0] SRC_A_REG = 2'b00, SRC_A_PC = 2'b01, SRC_A_ALUOUT = 2'b10;
  localparam logic [1:0] SRC_B_REG = 2'b00, SRC_B_IMM = 2'b01, SRC_B_FOUR = 2'b10;

  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       adr_src;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] imm_src;
    logic [1:0] reg_src;
    logic [1:0] alu_ctl;
    logic       fault;
  } ctl_t;

  typedef struct packed {
    logic       valid;
    logic [1:0] ctl;
    logic       cmp;
    logic       arith;  // command produces meaningful C and V
  } alu_dec_t;

  function automatic alu_dec_t decode_cmd(input logic [3:0] cmd);
    alu_dec_t d;
    d = '{valid: 1'b1, ctl: ALU_ADD, cmp: 1'b0, arith: 1'b1};
    case (cmd)
      CMD_ADD: d.ctl = ALU_ADD;
      CMD_SUB: d.ctl = ALU_SUB;
      CMD_AND: begin d.ctl = ALU_AND; d.arith = 1'b0; end
      CMD_ORR: begin d.ctl = ALU_ORR; d.arith = 1'b0; end
      CMD_CMP: begin d.ctl = ALU_SUB; d.cmp = 1'b1; end
      default: begin d.valid = 1'b0; d.arith = 1'b0; end
    endcase
    return d;
  endfunction

endpackage

// File: rtl/arm_cond_unit.sv
// ARM condition-code evaluation against an NZCV flag vector; code 1111 never passes.
module arm_cond_unit
  import arm_mc_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       cond_ok
);
  logic n, z, c, v;
  assign {n, z, c, v} = flags;

  always_comb begin
    cond_ok = 1'b0;
    case (cond)
      COND_EQ: cond_ok = z;
      COND_NE: cond_ok = !z;
      COND_CS: cond_ok = c;
      COND_CC: cond_ok = !c;
      COND_MI: cond_ok = n;
      COND_PL: cond_ok = !n;
      COND_VS: cond_ok = v;
      COND_VC: cond_ok = !v;
      COND_HI: cond_ok = c && !z;
      COND_LS: cond_ok = !c || z;
      COND_GE: cond_ok = (n == v);
      COND_LT: cond_ok = (n != v);
      COND_GT: cond_ok = !z && (n == v);
      COND_LE: cond_ok = z || (n != v);
      COND_AL: cond_ok = 1'b1;
      COND_NV: cond_ok = 1'b0;
      default: cond_ok = 1'b0;
    endcase
  end
endmodule

// File: rtl/arm_mc_controller.sv
// Multicycle ARM control FSM: sequences fetch/decode/execute over a shared memory
// port with a ready/request handshake, wait timeout, NZCV register and sticky fault.
module arm_mc_controller
  import arm_mc_pkg::*;
#(
  parameter int MAX_WAIT = 16,
  parameter int WAIT_W   = $clog2(MAX_WAIT + 1)
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] cond,
  input  logic [1:0] op,
  input  logic [5:0] funct,
  input  logic [3:0] rd,
  input  logic [3:0] alu_flags,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] imm_src,
  output logic [1:0] reg_src,
  output logic [1:0] alu_ctl,
  output logic [3:0] flags,
  output logic       fault
);
  localparam int CNT_W = (WAIT_W < 1) ? 1 : WAIT_W;

  state_t           state_reg, state_next;
  logic [3:0]       flags_reg;
  logic [CNT_W-1:0] wait_cnt_reg;
  logic             cond_ok;
  logic             rd_pc;
  alu_dec_t         dec;
  ctl_t             ctl_c, ctl;

  arm_cond_unit u_cond (.cond(cond), .flags(flags_reg), .cond_ok(cond_ok));

  assign dec   = decode_cmd(funct[4:1]);
  assign rd_pc = (rd == 4'd15);

  always_comb begin
    ctl_c         = '0;
    ctl_c.imm_src = op;
    ctl_c.reg_src = {op == OP_MEM, op == OP_BR};
    ctl_c.alu_ctl = ALU_ADD;
    state_next    = state_reg;
    case (state_reg)
      S_FETCH: begin
        ctl_c.mem_req    = 1'b1;
        ctl_c.alu_src_a  = SRC_A_PC;
        ctl_c.alu_src_b  = SRC_B_FOUR;
        ctl_c.result_src = RES_ALU;
        if (mem_ready) begin
          ctl_c.ir_write = 1'b1;
          ctl_c.pc_write = 1'b1;
          state_next     = S_DECODE;
        end
      end
      S_DECODE: begin
        ctl_c.alu_src_a = SRC_A_PC;
        ctl_c.alu_src_b = SRC_B_FOUR;
        case (op)
          OP_MEM:  state_next = S_MEMADR;
          OP_DP:   state_next = funct[5] ? S_EXECI : S_EXECR;
          OP_BR:   state_next = S_BRANCH;
          default: state_next = S_FAULT;
        endcase
      end
      S_MEMADR: begin
        ctl_c.alu_src_b = SRC_B_IMM;
        state_next      = funct[0] ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        ctl_c.mem_req = 1'b1;
        ctl_c.adr_src = 1'b1;
        if (mem_ready) state_next = S_MEMWB;
      end
      S_MEMWB: begin
        ctl_c.result_src = RES_RDATA;
        ctl_c.reg_write  = cond_ok;
        ctl_c.pc_write   = cond_ok && rd_pc;
        state_next       = S_FETCH;
      end
      S_MEMWRITE: begin
        // A failed condition skips the bus cycle entirely
        ctl_c.adr_src   = 1'b1;
        ctl_c.mem_req   = cond_ok;
        ctl_c.mem_write = cond_ok;
        if (!cond_ok || mem_ready) state_next = S_FETCH;
      end
      S_EXECR, S_EXECI: begin
        ctl_c.alu_src_b = (state_reg == S_EXECI) ? SRC_B_IMM : SRC_B_REG;
        ctl_c.alu_ctl   = dec.ctl;
        state_next      = dec.valid ? S_ALUWB : S_FAULT;
      end
      S_ALUWB: begin
        ctl_c.alu_ctl   = dec.ctl;
        ctl_c.reg_write = cond_ok && !dec.cmp;
        ctl_c.pc_write  = cond_ok && rd_pc && !dec.cmp;
        state_next      = S_FETCH;
      end
      S_BRANCH: begin
        ctl_c.alu_src_a  = SRC_A_ALUOUT;
        ctl_c.alu_src_b  = SRC_B_IMM;
        ctl_c.result_src = RES_ALU;
        ctl_c.pc_write   = cond_ok;
        state_next       = S_FETCH;
      end
      S_FAULT: begin
        ctl_c       = '0;
        ctl_c.fault = 1'b1;
      end
      default: state_next = S_FAULT;
    endcase
    // The cycle that would bring the wait count to MAX_WAIT is the last one tolerated
    if (MAX_WAIT != 0 && ctl_c.mem_req && !mem_ready && (int'(wait_cnt_reg) + 1 >= MAX_WAIT))
      state_next = S_FAULT;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= S_FETCH;
      flags_reg    <= '0;
      wait_cnt_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (state_next != state_reg)
        wait_cnt_reg <= '0;
      else if (ctl_c.mem_req && !mem_ready)
        wait_cnt_reg <= wait_cnt_reg + CNT_W'(1);
      if (state_reg == S_ALUWB && cond_ok && (funct[0] || dec.cmp)) begin
        flags_reg[3:2] <= alu_flags[3:2];
        if (dec.arith) flags_reg[1:0] <= alu_flags[1:0];
      end
    end
  end

  assign ctl        = reset_n ? ctl_c : '0;
  assign mem_req    = ctl.mem_req;
  assign mem_write  = ctl.mem_write;
  assign adr_src    = ctl.adr_src;
  assign ir_write   = ctl.ir_write;
  assign pc_write   = ctl.pc_write;
  assign reg_write  = ctl.reg_write;
  assign result_src = ctl.result_src;
  assign alu_src_a  = ctl.alu_src_a;
  assign alu_src_b  = ctl.alu_src_b;
  assign imm_src    = ctl.imm_src;
  assign reg_src    = ctl.reg_src;
  assign alu_ctl    = ctl.alu_ctl;
  assign fault      = ctl.fault;
  assign flags      = flags_reg;

endmodule

// File: tb/tb_arm_mc_controller.sv
// Randomised bench for arm_mc_controller: each instruction is scored by per-instruction
// strobe counts, latency and resulting flags computed from the ARM instruction rules.
module tb_arm_mc_controller;
  localparam int MAXW = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] cond = 4'h0, rd = 4'h0, alu_flags = 4'h0;
  logic [1:0] op = 2'b00;
  logic [5:0] funct = 6'h00;
  logic       mem_ready = 1'b0;
  logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, fault;
  logic [1:0] result_src, alu_src_a, alu_src_b, imm_src, reg_src, alu_ctl;
  logic [3:0] flags;

  int n_cmp = 0;
  int n_bad = 0;
  int n_txn = 0;
  logic [3:0] model_flags = 4'h0;

  arm_mc_controller #(.MAX_WAIT(MAXW)) dut (
    .clk(clk), .reset_n(reset_n), .cond(cond), .op(op), .funct(funct), .rd(rd),
    .alu_flags(alu_flags), .mem_ready(mem_ready), .mem_req(mem_req), .mem_write(mem_write),
    .adr_src(adr_src), .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
    .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .imm_src(imm_src), .reg_src(reg_src), .alu_ctl(alu_ctl), .flags(flags), .fault(fault)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] all_outs();
    return {11'd0, mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, result_src,
            alu_src_a, alu_src_b, imm_src, reg_src, alu_ctl, fault};
  endfunction

  // Odd codes invert the even code's test; 111x is always / never.
  function automatic logic cond_holds(input logic [3:0] c, input logic [3:0] fl);
    logic n, z, cy, v, base;
    {n, z, cy, v} = fl;
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: return !c[0];
    endcase
    return base ^ c[0];
  endfunction

  task automatic do_reset(input string tag);
    reset_n = 1'b0;
    #1;
    check_eq({tag, "_outs"}, all_outs(), 32'd0);
    check_eq({tag, "_flags"}, {28'd0, flags}, 32'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    #1 check_eq({tag, "_first_req"}, {31'd0, mem_req}, 32'd1);
    model_flags = 4'h0;
  endtask

  task automatic run_instr(input logic [3:0] c, input logic [1:0] o, input logic [5:0] f,
                           input logic [3:0] r, input logic [3:0] af, input int wf, input int wm);
    int exp_cyc, exp_req, exp_rw, exp_pw, exp_mw;
    int n_req, n_rw, n_pw, n_mw, n_ir, last_rw, acc, run;
    int waits[2];
    logic cok, is_cmp, arith, is_dp;
    logic [1:0] exp_ctl, last_ctl;
    logic req_now;
    n_req = 0; n_rw = 0; n_pw = 0; n_mw = 0; n_ir = 0; last_rw = -1; acc = 0; run = 0;
    waits[0] = wf; waits[1] = wm;
    cok = cond_holds(c, model_flags);
    is_cmp = 1'b0; arith = 1'b0; is_dp = 1'b0; exp_ctl = 2'b00; last_ctl = 2'b00;
    exp_mw = 0;
    case (o)
      2'b00: begin
        is_dp = 1'b1;
        case (f[4:1])
          4'b0100: begin exp_ctl = 2'b00; arith = 1'b1; end
          4'b0010: begin exp_ctl = 2'b01; arith = 1'b1; end
          4'b0000: exp_ctl = 2'b10;
          4'b1100: exp_ctl = 2'b11;
          4'b1010: begin exp_ctl = 2'b01; arith = 1'b1; is_cmp = 1'b1; end
          default: ;
        endcase
        exp_cyc = 4 + wf;
        exp_req = 1 + wf;
        exp_rw  = (cok && !is_cmp) ? 1 : 0;
        exp_pw  = 1 + ((cok && !is_cmp && r == 4'd15) ? 1 : 0);
      end
      2'b01: begin
        if (f[0]) begin
          exp_cyc = 5 + wf + wm;
          exp_req = 2 + wf + wm;
          exp_rw  = cok ? 1 : 0;
          exp_pw  = 1 + ((cok && r == 4'd15) ? 1 : 0);
        end else begin
          exp_cyc = 4 + wf + (cok ? wm : 0);
          exp_req = 1 + wf + (cok ? 1 + wm : 0);
          exp_rw  = 0;
          exp_pw  = 1;
          exp_mw  = cok ? 1 + wm : 0;
        end
      end
      default: begin
        exp_cyc = 3 + wf;
        exp_req = 1 + wf;
        exp_rw  = 0;
        exp_pw  = 1 + (cok ? 1 : 0);
      end
    endcase

    for (int cyc = 0; cyc < exp_cyc; cyc++) begin
      @(negedge clk);
      if (cyc == 0) begin
        cond = c; op = o; funct = f; rd = r; alu_flags = af;
      end
      #1;
      req_now = mem_req;
      if (cyc == 0) check_eq("start_req", {31'd0, mem_req}, 32'd1);
      if (req_now) begin
        mem_ready = (acc > 1) ? 1'b1 : (run >= waits[acc]);
        if (mem_ready) begin acc++; run = 0; end
        else run++;
      end else begin
        mem_ready = 1'($urandom_range(0, 1));
      end
      #1;
      n_req += int'(req_now);
      n_rw  += int'(reg_write);
      n_pw  += int'(pc_write);
      n_mw  += int'(mem_write);
      n_ir  += int'(ir_write);
      if (reg_write) last_rw = cyc;
      last_ctl = alu_ctl;
    end

    check_eq("req_cycles", n_req, exp_req);
    check_eq("reg_write_cnt", n_rw, exp_rw);
    check_eq("pc_write_cnt", n_pw, exp_pw);
    check_eq("mem_write_cnt", n_mw, exp_mw);
    check_eq("ir_write_cnt", n_ir, 1);
    if (exp_rw != 0) check_eq("reg_write_last", last_rw, exp_cyc - 1);
    if (is_dp) check_eq("wb_alu_ctl", {30'd0, last_ctl}, {30'd0, exp_ctl});
    if (is_dp && cok && (f[0] || is_cmp)) begin
      model_flags[3:2] = af[3:2];
      if (arith) model_flags[1:0] = af[1:0];
    end
    @(posedge clk);
    #1 check_eq("flags", {28'd0, flags}, {28'd0, model_flags});
    $display("txn %0d: cond=%h op=%b funct=%b rd=%0d af=%b waits=%0d/%0d cycles=%0d cond_ok=%0b flags=%b",
             n_txn, c, o, f, r, af, wf, wm, exp_cyc, cok, model_flags);
    n_txn++;
  endtask

  task automatic expect_fault(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1 check_eq({tag, "_pre"}, {31'd0, fault}, 32'd0);
    end
    @(negedge clk);
    #1 check_eq({tag, "_fault"}, {31'd0, fault}, 32'd1);
    check_eq({tag, "_req"}, {31'd0, mem_req}, 32'd0);
    for (int i = 0; i < 2; i++) begin
      mem_ready = ~mem_ready;
      @(negedge clk);
      #1 check_eq({tag, "_sticky"}, {31'd0, fault}, 32'd1);
      check_eq({tag, "_held_req"}, {31'd0, mem_req}, 32'd0);
    end
    $display("fault %s: entered after %0d cycles", tag, n);
  endtask

  initial begin
    logic [31:0] ins;
    logic [3:0] c, r;
    logic [5:0] f;
    logic [1:0] o;
    logic [3:0] cmds[5];
    cmds[0] = 4'b0100; cmds[1] = 4'b0010; cmds[2] = 4'b0000; cmds[3] = 4'b1100; cmds[4] = 4'b1010;

    #1;
    check_eq("rst_fault", {31'd0, fault}, 32'd0);
    do_reset("rst_init");

    ins = 32'hE084D005;
    run_instr(ins[31:28], ins[27:26], ins[25:20], ins[15:12], 4'b0000, 0, 0);
    run_instr(4'hE, 2'b01, 6'b011001, 4'd2, 4'b0000, 0, 3);
    run_instr(4'hE, 2'b00, 6'b010101, 4'd5, 4'b0110, 0, 0);
    check_eq("cmp_flags", {28'd0, flags}, 32'h6);
    run_instr(4'h0, 2'b00, 6'b001000, 4'd1, 4'b0000, 0, 0);
    run_instr(4'h1, 2'b00, 6'b001000, 4'd1, 4'b0000, 0, 0);
    run_instr(4'h1, 2'b01, 6'b011000, 4'd3, 4'b0000, 1, 2);
    run_instr(4'hE, 2'b10, 6'b101010, 4'd0, 4'b0000, 2, 0);

    for (int t = 0; t < 80; t++) begin
      c = ($urandom_range(0, 2) == 0) ? 4'hE : 4'($urandom_range(0, 15));
      r = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom_range(0, 15));
      case ($urandom_range(0, 3))
        0, 1: begin o = 2'b00; f = {1'($urandom_range(0, 1)), cmds[$urandom_range(0, 4)], 1'($urandom_range(0, 1))}; end
        2: begin o = 2'b01; f = 6'($urandom_range(0, 63)); end
        default: begin o = 2'b10; f = 6'($urandom_range(0, 63)); end
      endcase
      run_instr(c, o, f, r, 4'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom_range(0, 3));
    end

    mem_ready = 1'b0;
    @(negedge clk);
    #1 check_eq("fetch_req", {31'd0, mem_req}, 32'd1);
    do_reset("rst_midfetch");

    cond = 4'hE; op = 2'b00; funct = 6'b001000; mem_ready = 1'b0;
    expect_fault("timeout", MAXW);
    do_reset("rst_timeout");

    cond = 4'hE; op = 2'b11; mem_ready = 1'b1;
    expect_fault("op11", 2);
    do_reset("rst_op11");

    cond = 4'hE; op = 2'b00; funct = 6'b011110; mem_ready = 1'b1;
    expect_fault("cmd_bad", 3);
    do_reset("rst_cmd");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
